// File: rtl/alien_hit_detector.sv
// -----------------------------------------------------------------------------
// alien_hit_detector
//
// Sequential collision checker between the player bullet and the alien
// formation. On a frame_tick with a bullet in flight it latches the bullet
// position and walks the formation one alien per cycle, bottom row first and
// left to right within a row, so the lowest alien in the bullet's path wins.
// The first overlap with a live alien produces a single one-cycle hit pulse
// for that alien plus a bullet-consume pulse. If nothing matches, scan_done
// pulses once the last alien has been checked.
//
// Ports:
//   clk               system clock
//   rst               synchronous reset, active-high
//   frame_tick        one-cycle scan request
//   bullet_active     player bullet in flight (dropping it aborts a scan)
//   bullet_x/y        bullet top-left position (latched at scan start)
//   alive_matrix      live aliens [row][col] (sampled live during the scan)
//   alien_positions_x/y  alien top-left positions [row][col] (sampled live)
//   hit_signals       one-hot, one-cycle hit pulse [row][col]
//   bullet_hit        one-cycle pulse coincident with hit_signals
//   hit_row/hit_col   coordinates of the last hit, held until the next hit
//   busy              high while a scan or its outcome cycle is in progress
//   scan_done         one-cycle pulse when a scan completes without a hit
// -----------------------------------------------------------------------------
module alien_hit_detector #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 5,
    parameter int ALIEN_W  = 32,
    parameter int ALIEN_H  = 16,
    parameter int BULLET_W = 2,
    parameter int BULLET_H = 8,
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     frame_tick,
    input  logic                                     bullet_active,
    input  logic [15:0]                              bullet_x,
    input  logic [15:0]                              bullet_y,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]        alive_matrix,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][15:0]  alien_positions_x,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][15:0]  alien_positions_y,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]        hit_signals,
    output logic                                     bullet_hit,
    output logic [ROW_W-1:0]                         hit_row,
    output logic [COL_W-1:0]                         hit_col,
    output logic                                     busy,
    output logic                                     scan_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HIT  = 2'd2;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

    // Axis-aligned box overlap, evaluated in 17 bits so the edge sums never wrap.
    function automatic logic box_overlap(
        input logic [15:0] bx,
        input logic [15:0] by,
        input logic [15:0] ax,
        input logic [15:0] ay
    );
        logic [16:0] bx17;
        logic [16:0] by17;
        logic [16:0] ax17;
        logic [16:0] ay17;
        bx17 = {1'b0, bx};
        by17 = {1'b0, by};
        ax17 = {1'b0, ax};
        ay17 = {1'b0, ay};
        box_overlap = (bx17 < (ax17 + 17'(ALIEN_W)))  &&
                      ((bx17 + 17'(BULLET_W)) > ax17) &&
                      (by17 < (ay17 + 17'(ALIEN_H)))  &&
                      ((by17 + 17'(BULLET_H)) > ay17);
    endfunction

    // FSM, scan index and latched bullet position
    logic [1:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [15:0]      bx_q, bx_d;
    logic [15:0]      by_q, by_d;
    // Set for the single cycle after the last alien missed: the scan is
    // finished but the FSM stays in SCAN so busy covers the scan_done cycle.
    logic             done_q, done_d;

    // Registered outputs
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] hit_signals_q, hit_signals_d;
    logic                              bullet_hit_q, bullet_hit_d;
    logic [ROW_W-1:0]                  hit_row_q, hit_row_d;
    logic [COL_W-1:0]                  hit_col_q, hit_col_d;
    logic                              busy_q, busy_d;
    logic                              scan_done_q, scan_done_d;

    logic alive_cur_s;
    logic match_s;
    logic last_idx_s;

    // Current alien under test: alive flag and positions are taken live.
    always_comb begin
        alive_cur_s = alive_matrix[row_q][col_q];
        match_s     = alive_cur_s &&
                      box_overlap(bx_q, by_q,
                                  alien_positions_x[row_q][col_q],
                                  alien_positions_y[row_q][col_q]);
        last_idx_s  = (row_q == {ROW_W{1'b0}}) && (col_q == COL_LAST);
    end

    // Next-state logic for the scan FSM and all registered outputs.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        bx_d          = bx_q;
        by_d          = by_q;
        done_d        = done_q;
        hit_signals_d = '0;
        bullet_hit_d  = 1'b0;
        hit_row_d     = hit_row_q;
        hit_col_d     = hit_col_q;
        scan_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && bullet_active) begin
                    state_d = ST_SCAN;
                    row_d   = ROW_LAST;
                    col_d   = {COL_W{1'b0}};
                    bx_d    = bullet_x;
                    by_d    = bullet_y;
                    done_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SCAN: begin
                if (!bullet_active) begin
                    // Bullet vanished: abandon the scan silently.
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (done_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else if (match_s) begin
                    state_d                     = ST_HIT;
                    hit_signals_d[row_q][col_q] = 1'b1;
                    bullet_hit_d                = 1'b1;
                    hit_row_d                   = row_q;
                    hit_col_d                   = col_q;
                end else if (last_idx_s) begin
                    done_d      = 1'b1;
                    scan_done_d = 1'b1;
                end else if (col_q == COL_LAST) begin
                    // Row finished: move one row up, restart at column 0.
                    row_d = row_q - ROW_W'(1);
                    col_d = {COL_W{1'b0}};
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end

            ST_HIT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, index, bullet latch and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            row_q         <= {ROW_W{1'b0}};
            col_q         <= {COL_W{1'b0}};
            bx_q          <= 16'd0;
            by_q          <= 16'd0;
            done_q        <= 1'b0;
            hit_signals_q <= '0;
            bullet_hit_q  <= 1'b0;
            hit_row_q     <= {ROW_W{1'b0}};
            hit_col_q     <= {COL_W{1'b0}};
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            bx_q          <= bx_d;
            by_q          <= by_d;
            done_q        <= done_d;
            hit_signals_q <= hit_signals_d;
            bullet_hit_q  <= bullet_hit_d;
            hit_row_q     <= hit_row_d;
            hit_col_q     <= hit_col_d;
            busy_q        <= busy_d;
            scan_done_q   <= scan_done_d;
        end
    end

    assign hit_signals = hit_signals_q;
    assign bullet_hit  = bullet_hit_q;
    assign hit_row     = hit_row_q;
    assign hit_col     = hit_col_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;

endmodule

// File: doc/alien_hit_detector.md
# alien_hit_detector

Sequential collision checker that produces the `hit_signals` matrix consumed by `alien_formation`. Once per frame it scans the formation one alien per cycle against the player bullet's bounding box. On the first overlap with a live alien it emits a single one-cycle hit pulse for that alien and a matching bullet-consume pulse back to the player-bullet logic. It sits between the player bullet block and `alien_formation`.

## Interface

Parameters:
- `NUM_ROWS`, 3: formation rows; must match `alien_formation`.
- `NUM_COLS`, 5: formation columns; must match `alien_formation`.
- `ALIEN_W`, 32: alien hitbox width in pixels.
- `ALIEN_H`, 16: alien hitbox height in pixels.
- `BULLET_W`, 2: bullet hitbox width in pixels.
- `BULLET_H`, 8: bullet hitbox height in pixels.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `frame_tick`  in  1  one-cycle pulse that requests a scan.
- `bullet_active`  in  1  player bullet is in flight.
- `bullet_x`, `bullet_y`  in  16 each  bullet top-left position.
- `alive_matrix`  in  [NUM_ROWS-1:0][NUM_COLS-1:0]  live aliens, from formation.
- `alien_positions_x`, `alien_positions_y`  in  16 × [NUM_ROWS-1:0][NUM_COLS-1:0]  alien top-left positions.
- `hit_signals`  out  [NUM_ROWS-1:0][NUM_COLS-1:0]  one-hot, one-cycle hit pulse.
- `bullet_hit`  out  1  one-cycle pulse, coincident with `hit_signals`.
- `hit_row`  out  $clog2(NUM_ROWS)  row of the last hit; held until the next hit.
- `hit_col`  out  $clog2(NUM_COLS)  column of the last hit; held until the next hit.
- `busy`  out  1  high while in SCAN or HIT.
- `scan_done`  out  1  one-cycle pulse when a scan completes with no hit.

## Operation

- FSM states: IDLE, SCAN, HIT.
- **IDLE**
  - If `frame_tick && bullet_active`: latch `bullet_x`/`bullet_y`, set row = NUM_ROWS-1 and col = 0, go to SCAN.
  - Otherwise stay in IDLE.
- **Scan order**: bottom row first (row NUM_ROWS-1 down to 0); within a row, col 0 up to NUM_COLS-1. Bullets travel upward, so the lowest alien wins.
- **SCAN, per cycle**: evaluate the current (row, col).
  - `alive_matrix` and the alien positions are sampled live, not latched.
  - The bullet position uses the latched copy.
- **Overlap test** (all arithmetic in 17 bits; no wrap):
  - bx < ax+ALIEN_W, and
  - bx+BULLET_W > ax, and
  - by < ay+ALIEN_H, and
  - by+BULLET_H > ay, and
  - the alien is alive.
- **On a match**: record (row, col), go to HIT.
- **On a miss**: advance the index.
  - After the last index (row 0, col NUM_COLS-1), pulse `scan_done` on the next cycle and return to IDLE.
- **HIT** (one cycle):
  - Drive `hit_signals[row][col]=1` with all other bits 0.
  - Drive `bullet_hit=1`.
  - Update `hit_row`/`hit_col`.
  - Return to IDLE.
- At most one hit per frame.
- `bullet_active` low during SCAN: abort to IDLE next cycle, with no hit and no `scan_done`.
- `frame_tick` while not in IDLE: ignored; it is not queued.
- `rst` at any time, including mid-scan: next cycle the FSM is in IDLE, indices are 0, and every output is 0 (`hit_signals`, `bullet_hit`, `hit_row`, `hit_col`, `busy`, `scan_done`).

## Timing

- N = NUM_ROWS·NUM_COLS. Cycle 0 is the cycle in which `frame_tick` is sampled high.
- Cycles 1..N: SCAN; scan index k is evaluated in cycle 1+k.
- Match at cycle t: `hit_signals`/`bullet_hit` are high during cycle t+1 only; IDLE from cycle t+2.
- No match: `scan_done` is high during cycle N+1; IDLE from cycle N+2.
- `busy` is high from cycle 1 through the HIT cycle, or through cycle N+1 on a miss.
- Worst-case latency N+1 cycles (16 at defaults); must be well below the frame period.

## Test plan

All scenarios use default parameters and formation geometry: START 100/50, spacing 64/32. Alien (2,0) is at (100,114).

- **Bottom-row hit**: all alive, bullet (110,120), tick at cycle 0 → `hit_signals[2][0]` and `bullet_hit` high at cycle 2 only; `hit_row`=2, `hit_col`=0.
- **Skip dead alien**: only (0,0) alive, bullet (110,60) → no pulse for (2,0); `hit_signals[0][0]` pulses at cycle 12 (index 10 evaluated at cycle 11).
- **Miss**: all alive, bullet (20,20) → `scan_done` high at cycle 16; `hit_signals` stays 0; `busy` low at cycle 17.
- **Hitbox edges**, target alien (2,0):
  - bullet_x=132 (= ax+ALIEN_W) → no hit on (2,0);
  - bullet_x=131 → hit;
  - bullet_x=98 → no hit (98+BULLET_W=100, not > ax);
  - bullet_x=99 → hit.
- **Abort and ignore**:
  - `bullet_active` drops at cycle 3 → `busy` low at cycle 4, no `hit_signals`, no `scan_done`.
  - A second `frame_tick` at cycle 5 during a scan → ignored; exactly one outcome pulse.
- **Reset mid-scan**: `rst` high at cycle 4 → all outputs 0 at cycle 5 and FSM in IDLE; a later tick rescans from (2,0).
